// File: rtl/playback_pkg.sv
// Shared types for the playback scheduler: FSM state encoding and default SD block size.
package playback_pkg;

  localparam int BLOCK_BYTES_DEF = 512;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    STREAM,
    FETCH,
    DRAIN,
    FAULT
  } state_t;

endpackage

// File: rtl/edge_detect.sv
// Per-bit rising-edge detector: pulse is high in the cycle the level first reads 1.
// Combinational pulse from a registered previous value; no backpressure.
module edge_detect #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] pulse
);

  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= '0;
    else        prev <= level;
  end

  assign pulse = level & ~prev;

endmodule

// File: rtl/playback_scheduler.sv
// Song playback sequencer: walks the selected song's byte range one SD block at a time.
// Outputs are registered one cycle after the deciding input; FIFO prog_empty throttles new reads.
module playback_scheduler
  import playback_pkg::*;
#(
  parameter int NUM_SONGS      = 4,
  parameter int BLOCK_BYTES    = BLOCK_BYTES_DEF,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_SONGS*32-1:0]      song_start,
  input  logic [NUM_SONGS*32-1:0]      song_end,
  input  logic                         select_in,
  input  logic                         up_in,
  input  logic                         down_in,
  input  logic                         stop_in,
  input  logic                         sd_done,
  input  logic                         fifo_prog_empty,
  input  logic                         fifo_empty,
  output logic                         read_req,
  output logic [31:0]                  sd_addr,
  output logic                         fifo_ready,
  output logic [$clog2(NUM_SONGS)-1:0] song_num,
  output logic                         playing,
  output logic                         error
);

  localparam int SW = $clog2(NUM_SONGS);

  state_t          state, state_nxt;
  logic [31:0]     end_addr, addr_nxt, end_nxt, tmo_cnt, cnt_nxt;
  logic [31:0]     sel_start, sel_end;
  logic [32:0]     addr_sum;
  logic [SW-1:0]   song_nxt;
  logic            rreq_nxt, frdy_nxt, err_nxt;
  logic [3:0]      btn_e;
  logic            sel_e, up_e, dn_e, stop_e;

  edge_detect #(.WIDTH(4)) u_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .level ({select_in, up_in, down_in, stop_in}),
    .pulse (btn_e)
  );

  assign {sel_e, up_e, dn_e, stop_e} = btn_e;

  assign sel_start = song_start[32*song_num +: 32];
  assign sel_end   = song_end[32*song_num +: 32];
  // Carry out of the block increment means the address space wrapped: song is over.
  assign addr_sum  = {1'b0, sd_addr} + 33'(BLOCK_BYTES);

  assign playing = (state == PRIME) || (state == STREAM) ||
                   (state == FETCH) || (state == DRAIN);

  always_comb begin
    state_nxt = state;
    addr_nxt  = sd_addr;
    end_nxt   = end_addr;
    song_nxt  = song_num;
    rreq_nxt  = 1'b0;
    frdy_nxt  = fifo_ready;
    err_nxt   = error;
    cnt_nxt   = tmo_cnt;
    case (state)
      IDLE: begin
        if (sel_e) begin
          addr_nxt = sel_start;
          end_nxt  = sel_end;
          if (sel_start < sel_end) begin
            state_nxt = PRIME;
            rreq_nxt  = 1'b1;
            cnt_nxt   = '0;
          end
        end else if (up_e && !dn_e) begin
          song_nxt = (song_num == SW'(NUM_SONGS - 1)) ? '0 : song_num + 1'b1;
        end else if (dn_e && !up_e) begin
          song_nxt = (song_num == '0) ? SW'(NUM_SONGS - 1) : song_num - 1'b1;
        end
      end
      PRIME, FETCH: begin
        if (stop_e) begin
          state_nxt = DRAIN;
        end else if (sd_done) begin
          addr_nxt  = addr_sum[31:0];
          frdy_nxt  = 1'b1;
          state_nxt = addr_sum[32] ? DRAIN : STREAM;
        end else if (tmo_cnt >= 32'(TIMEOUT_CYCLES - 1)) begin
          state_nxt = FAULT;
          err_nxt   = 1'b1;
          frdy_nxt  = 1'b0;
        end else begin
          cnt_nxt = tmo_cnt + 32'd1;
        end
      end
      STREAM: begin
        if (stop_e || sd_addr >= end_addr) begin
          state_nxt = DRAIN;
        end else if (fifo_prog_empty) begin
          state_nxt = FETCH;
          rreq_nxt  = 1'b1;
          cnt_nxt   = '0;
        end
      end
      DRAIN: begin
        if (fifo_empty) begin
          state_nxt = IDLE;
          frdy_nxt  = 1'b0;
        end
      end
      FAULT: begin
        if (sel_e) begin
          state_nxt = IDLE;
          err_nxt   = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sd_addr    <= song_start[31:0];
      end_addr   <= '0;
      song_num   <= '0;
      read_req   <= 1'b0;
      fifo_ready <= 1'b0;
      error      <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      sd_addr    <= addr_nxt;
      end_addr   <= end_nxt;
      song_num   <= song_nxt;
      read_req   <= rreq_nxt;
      fifo_ready <= frdy_nxt;
      error      <= err_nxt;
      tmo_cnt    <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_playback_scheduler.sv
// Randomized bench for playback_scheduler: songs are checked against read counts and addresses
// derived arithmetically from each song's byte range, plus menu, timeout, stop and reset scenarios.
module tb_playback_scheduler;

  localparam int N   = 4;
  localparam int BB  = 512;
  localparam int TMO = 100;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [31:0]     st [N];
  logic [31:0]     en [N];
  logic [N*32-1:0] song_start, song_end;
  logic select_in = 1'b0, up_in = 1'b0, down_in = 1'b0, stop_in = 1'b0;
  logic sd_done = 1'b0, fifo_prog_empty = 1'b1, fifo_empty = 1'b0;
  logic            read_req, fifo_ready, playing, error;
  logic [31:0]     sd_addr;
  logic [1:0]      song_num;

  int checks = 0, failures = 0;
  int cyc = 0, done_cnt = 0, done_dly = 10, last_req_cyc = 0, viol = 0;
  int exp_song = 0, r, k;
  bit auto_done = 1'b1, rand_pe = 1'b0, outstanding = 1'b0;
  logic [31:0] reqs[$];

  always #20 clk = ~clk;

  always_comb begin
    song_start = '0;
    song_end   = '0;
    for (int i = 0; i < N; i++) begin
      song_start[32*i +: 32] = st[i];
      song_end[32*i +: 32]   = en[i];
    end
  end

  playback_scheduler #(.NUM_SONGS(N), .BLOCK_BYTES(BB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .song_start      (song_start),
    .song_end        (song_end),
    .select_in       (select_in),
    .up_in           (up_in),
    .down_in         (down_in),
    .stop_in         (stop_in),
    .sd_done         (sd_done),
    .fifo_prog_empty (fifo_prog_empty),
    .fifo_empty      (fifo_empty),
    .read_req        (read_req),
    .sd_addr         (sd_addr),
    .fifo_ready      (fifo_ready),
    .song_num        (song_num),
    .playing         (playing),
    .error           (error)
  );

  // SD card / FIFO model: logs every read, answers after done_dly cycles, flags protocol breaks.
  always @(posedge clk) begin
    #1;
    cyc++;
    sd_done = 1'b0;
    if (done_cnt == 1) begin
      sd_done     = 1'b1;
      outstanding = 1'b0;
    end
    if (done_cnt > 0) done_cnt--;
    if (read_req) begin
      if (outstanding || !playing) viol++;
      outstanding  = 1'b1;
      last_req_cyc = cyc;
      reqs.push_back(sd_addr);
      if (auto_done) done_cnt = done_dly;
    end
    fifo_prog_empty = rand_pe ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic press(input logic s, input logic u, input logic d, input logic p);
    select_in = s; up_in = u; down_in = d; stop_in = p;
    tick();
    select_in = 1'b0; up_in = 1'b0; down_in = 1'b0; stop_in = 1'b0;
    tick();
  endtask

  task automatic goto_song(input int idx);
    for (int j = 0; j < N && exp_song != idx; j++) begin
      press(1'b0, 1'b1, 1'b0, 1'b0);
      exp_song = (exp_song + 1) % N;
    end
    chk("goto_song", 32'(song_num), 32'(idx));
  endtask

  task automatic wait_nreq(input int n, input bit need_quiet, input string tag);
    int b;
    b = 0;
    while ((reqs.size() < n || (need_quiet && outstanding)) && b < 3000) begin
      tick();
      b++;
    end
    chk({tag, "_wait"}, 32'(b < 3000), 32'd1);
  endtask

  task automatic play(input int idx, input string tag);
    int n;
    goto_song(idx);
    reqs.delete();
    fifo_empty = 1'b0;
    press(1'b1, 1'b0, 1'b0, 1'b0);
    n = (en[idx] > st[idx]) ? int'((64'(en[idx]) - 64'(st[idx]) + BB - 1) / BB) : 0;
    wait_nreq(n, 1'b1, tag);
    repeat (6) tick();
    chk({tag, "_nreq"}, 32'(reqs.size()), 32'(n));
    for (int j = 0; j < reqs.size() && j < n; j++)
      chk({tag, "_addr"}, reqs[j], st[idx] + 32'(j * BB));
    chk({tag, "_playing"}, 32'(playing), 32'(n > 0));
    chk({tag, "_frdy_hold"}, 32'(fifo_ready), 32'(n > 0));
    fifo_empty = 1'b1;
    tick();
    chk({tag, "_frdy_fall"}, 32'(fifo_ready), 32'd0);
    tick();
    chk({tag, "_idle"}, 32'(playing), 32'd0);
  endtask

  initial begin
    st[0] = 32'd0;       en[0] = 32'd1536;
    st[1] = 32'h10000;   en[1] = 32'h10000 + 32'(8 * BB);
    st[2] = 32'd100;     en[2] = 32'd700;
    st[3] = 32'd4096;    en[3] = 32'd4096;
    #5;
    chk("rst_read_req", 32'(read_req), 32'd0);
    chk("rst_fifo_ready", 32'(fifo_ready), 32'd0);
    chk("rst_playing", 32'(playing), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_song_num", 32'(song_num), 32'd0);
    chk("rst_sd_addr", sd_addr, st[0]);
    tick();
    rst_n = 1'b1;
    tick();

    // Menu navigation with wrap in both directions.
    press(1'b0, 1'b0, 1'b1, 1'b0); exp_song = 3;
    chk("menu_down_wrap", 32'(song_num), 32'(exp_song));
    press(1'b0, 1'b1, 1'b0, 1'b0); exp_song = 0;
    chk("menu_up_wrap", 32'(song_num), 32'(exp_song));
    press(1'b0, 1'b1, 1'b1, 1'b0);
    chk("menu_both", 32'(song_num), 32'(exp_song));
    for (int i = 0; i < 12; i++) begin
      r = $urandom_range(0, 2);
      press(1'b0, (r != 1), (r != 0), 1'b0);
      if (r == 0)      exp_song = (exp_song + 1) % N;
      else if (r == 1) exp_song = (exp_song + N - 1) % N;
      chk("menu_rand", 32'(song_num), 32'(exp_song));
    end

    // Reference song: three blocks, sd_done 10 cycles after each request.
    done_dly = 10;
    play(0, "song0");

    // Randomized songs, including an address-space wrap and empty/inverted ranges.
    rand_pe = 1'b1;
    for (int i = 0; i < 7; i++) begin
      k = 1 + $urandom_range(0, 1);
      done_dly = $urandom_range(1, 15);
      if (i == 0) begin
        st[k] = 32'hFFFF_FF00;
        en[k] = 32'hFFFF_FFFF;
      end else begin
        st[k] = $urandom_range(0, 100000);
        if ($urandom_range(0, 4) == 0) en[k] = st[k] / 2;
        else                           en[k] = st[k] + $urandom_range(1, 3000);
      end
      play(k, "rand");
    end
    rand_pe = 1'b0;

    // Timeout: no sd_done after the first request.
    auto_done = 1'b0;
    goto_song(0);
    reqs.delete();
    fifo_empty = 1'b0;
    press(1'b1, 1'b0, 1'b0, 1'b0);
    k = 0;
    while (!error && k < 400) begin
      tick();
      k++;
    end
    chk("tmo_error", 32'(error), 32'd1);
    chk("tmo_latency", 32'(cyc - last_req_cyc), 32'(TMO));
    chk("tmo_fifo_ready", 32'(fifo_ready), 32'd0);
    chk("tmo_playing", 32'(playing), 32'd0);
    outstanding = 1'b0;
    auto_done = 1'b1;
    press(1'b0, 1'b0, 1'b0, 1'b1);
    chk("fault_stop_ignored", 32'(error), 32'd1);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) tick();
    chk("fault_clear", 32'(error), 32'd0);
    chk("fault_no_read", 32'(reqs.size()), 32'd1);
    chk("fault_idle", 32'(playing), 32'd0);

    // Stop while a FETCH read is outstanding.
    st[1] = 32'h10000; en[1] = 32'h10000 + 32'(8 * BB);
    done_dly = 20;
    goto_song(1);
    reqs.delete();
    fifo_empty = 1'b0;
    press(1'b1, 1'b0, 1'b0, 1'b0);
    wait_nreq(2, 1'b0, "stop");
    repeat (3) tick();
    chk("stop_pending", 32'(outstanding), 32'd1);
    press(1'b0, 1'b0, 1'b0, 1'b1);
    wait_nreq(2, 1'b1, "stop_done");
    repeat (10) tick();
    chk("stop_nreq", 32'(reqs.size()), 32'd2);
    chk("stop_drain", 32'(playing), 32'd1);
    fifo_empty = 1'b1;
    tick(); tick();
    chk("stop_idle", 32'(playing), 32'd0);
    chk("stop_frdy", 32'(fifo_ready), 32'd0);

    // Reset in the middle of a FETCH, with the old sd_done arriving afterwards.
    fifo_empty = 1'b0;
    reqs.delete();
    press(1'b1, 1'b0, 1'b0, 1'b0);
    wait_nreq(2, 1'b0, "rstf");
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    chk("rstf_read_req", 32'(read_req), 32'd0);
    chk("rstf_fifo_ready", 32'(fifo_ready), 32'd0);
    chk("rstf_playing", 32'(playing), 32'd0);
    chk("rstf_error", 32'(error), 32'd0);
    chk("rstf_song_num", 32'(song_num), 32'd0);
    chk("rstf_sd_addr", sd_addr, st[0]);
    outstanding = 1'b0;
    exp_song = 0;
    tick();
    rst_n = 1'b1;
    repeat (40) tick();
    chk("rstf_late_done_nreq", 32'(reqs.size()), 32'd2);
    chk("rstf_late_done_idle", 32'(playing), 32'd0);
    chk("rstf_late_done_addr", sd_addr, st[0]);
    play(0, "post_rst");

    // Empty song entry.
    goto_song(3);
    reqs.delete();
    press(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (20) tick();
    chk("empty_nreq", 32'(reqs.size()), 32'd0);
    chk("empty_idle", 32'(playing), 32'd0);
    chk("empty_addr", sd_addr, 32'd4096);

    chk("protocol_violations", 32'(viol), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/playback_scheduler.md
PLAYBACK_SCHEDULER -- requirements
Module: playback_scheduler

Interface
REQ-001 The parameter NUM_SONGS SHALL default to 4 and give the number of song-table entries (range 2..16).
REQ-002 The parameter BLOCK_BYTES SHALL default to 512 and give the byte increment per SD block read.
REQ-003 The parameter TIMEOUT_CYCLES SHALL default to 2_000_000 and give the maximum number of clk cycles between a read_req and sd_done.
REQ-004 The port clk SHALL be an input, 1 bit wide, and is the single clock: 25 MHz, rising edge.
REQ-005 The port rst_n SHALL be an input, 1 bit wide, and is the reset: asynchronous, active-low.
REQ-006 The port song_start SHALL be an input of NUM_SONGS*32 bits giving the flattened start byte addresses (entry i at bits [32i+31:32i]).
REQ-007 The port song_end SHALL be an input of NUM_SONGS*32 bits giving the flattened exclusive end byte addresses.
REQ-008 The ports select_in, up_in and down_in SHALL be 1-bit inputs carrying debounced, level-sensitive buttons.
REQ-009 The port stop_in SHALL be a 1-bit input, level-sensitive, that aborts playback.
REQ-010 The port sd_done SHALL be a 1-bit input, one-cycle pulse, meaning the SD block transfer is complete.
REQ-011 The ports fifo_prog_empty and fifo_empty SHALL be 1-bit inputs giving the FIFO status (prog_empty means at least BLOCK_BYTES free).
REQ-012 The port read_req SHALL be a 1-bit output, one-cycle pulse, that starts an SD block read.
REQ-013 The port sd_addr SHALL be a 32-bit output giving the byte address of the current or next block.
REQ-014 The port fifo_ready SHALL be a 1-bit output that is high while the transmitter may consume FIFO data.
REQ-015 The port song_num SHALL be a $clog2(NUM_SONGS)-bit output giving the menu selection.
REQ-016 The ports playing and error SHALL be 1-bit status outputs.

Function
REQ-017 Button edges SHALL be detected internally: an event is in=1 with the registered previous value=0, and only the rising edge acts.
REQ-018 The states SHALL be IDLE, PRIME, STREAM, FETCH, DRAIN and FAULT.
REQ-019 In IDLE, an up edge SHALL set song_num+1 and a down edge SHALL set song_num-1, both modulo NUM_SONGS with wrap in both directions.
REQ-020 In IDLE, simultaneous up and down edges SHALL leave song_num unchanged, and select has priority over up/down in the same cycle.
REQ-021 In IDLE, a select edge SHALL load sd_addr<=start[song_num] and latch end[song_num]; when start>=end the block SHALL remain in IDLE, otherwise it SHALL pulse read_req on the next cycle and enter PRIME.
REQ-022 In PRIME, on sd_done the block SHALL set sd_addr+=BLOCK_BYTES and fifo_ready<=1, then go to STREAM.
REQ-023 In STREAM, when sd_addr>=latched end the block SHALL go to DRAIN; else when fifo_prog_empty=1 it SHALL pulse read_req and go to FETCH.
REQ-024 At most one read SHALL be outstanding, and read_req SHALL never assert outside the IDLE->PRIME and STREAM->FETCH transitions.
REQ-025 In FETCH, on sd_done the block SHALL set sd_addr+=BLOCK_BYTES and return to STREAM; a further read_req SHALL issue no earlier than 1 cycle after sd_done.
REQ-026 In DRAIN, when fifo_empty=1 the block SHALL clear fifo_ready and go to IDLE.
REQ-027 playing SHALL be 1 in PRIME, STREAM, FETCH and DRAIN, and 0 otherwise.
REQ-028 The timeout counter SHALL be 32-bit, clear on every read_req, and increment in PRIME/FETCH; on reaching TIMEOUT_CYCLES the block SHALL set error=1, clear fifo_ready and enter FAULT.
REQ-029 FAULT SHALL be exited only by a select edge, which clears error and returns to IDLE without starting a read.
REQ-030 A stop edge in any playing state SHALL go to DRAIN without issuing new reads; a pending sd_done SHALL still be accepted (its address increment ignored).
REQ-031 A stop edge in IDLE or FAULT SHALL have no effect.
REQ-032 The address adder SHALL be 32 bits wide and unsigned; on wrap past 2^32-1 the block SHALL treat the song as complete (go to DRAIN).
REQ-033 sd_done arriving in IDLE, STREAM or FAULT SHALL be ignored.

Reset
REQ-034 On rst_n=0, asynchronously: state=IDLE, read_req=0, fifo_ready=0, playing=0, error=0, song_num=0, sd_addr=song_start entry 0, timeout counter=0, and edge-detect registers=0.
REQ-035 Reset asserted mid-FETCH SHALL abandon the read; the first read after reset SHALL be a fresh PRIME.

Structure
REQ-036 The state enum and the BLOCK_BYTES default SHALL reside in a shared package, playback_pkg.
REQ-037 A single sub-module, edge_detect (per-bit rising-edge pulse, async active-low reset), SHALL be instantiated for the select, up, down and stop inputs.

Verification
REQ-038 Select song 0 (start=0, end=1536) with sd_done 10 cycles after each read_req and prog_empty=1 -> exactly 3 read_req at sd_addr 0, 512 and 1024, then DRAIN, and fifo_ready falls 1 cycle after fifo_empty.
REQ-039 In IDLE with NUM_SONGS=4, down edge from song_num=0 -> 3; up edge from 3 -> 0; simultaneous up+down -> unchanged.
REQ-040 Hold sd_done low after read_req for TIMEOUT_CYCLES=100 -> error=1 at cycle 100 and fifo_ready=0; then a select edge -> IDLE with error=0.
REQ-041 Stop edge in FETCH, then sd_done -> no further read_req, DRAIN, and IDLE after fifo_empty.
REQ-042 Deassert rst_n mid-FETCH and release it -> all outputs at reset values immediately, and a late sd_done is ignored.
REQ-043 Select an entry with start=end=4096 -> no read_req and the block stays in IDLE.
